// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for pipeline stage buffers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       mem_read;
    logic [2:0] funct3;
  } decode_ctrl_t;

  localparam int CTRL_W      = $bits(decode_ctrl_t);
  localparam int DEPTH_PLAIN = 1;
  localparam int DEPTH_SKID  = 2;

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_slot : one valid+ctrl+data register, ctrl zeroed when invalid   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Clearing only drops valid and ctrl; the payload is left in place.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_buf : valid/ready pipeline stage register, optional skid  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int  DATA_W  = 128,
  parameter int  CTRL_W  = pipe_pkg::CTRL_W,
  parameter int  DEPTH   = pipe_pkg::DEPTH_PLAIN,
  localparam int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] count
);

  logic               accept;
  logic               emit;
  logic               main_load;
  logic               main_clear;
  logic [CTRL_W-1:0]  main_ctrl_d;
  logic [DATA_W-1:0]  main_data_d;
  logic [COUNT_W-1:0] count_q, count_d;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear_i (main_clear),
    .load_i  (main_load),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (out_valid),
    .ctrl_o  (out_ctrl),
    .data_o  (out_data)
  );

  generate
    if (DEPTH == DEPTH_PLAIN) begin : g_plain
      assign in_ready    = reset & (~out_valid | out_ready);
      assign main_load   = accept & ~flush;
      assign main_clear  = flush | (emit & ~accept);
      assign main_ctrl_d = in_ctrl;
      assign main_data_d = in_data;
    end else if (DEPTH == DEPTH_SKID) begin : g_skid
      logic              skid_valid;
      logic              skid_load;
      logic              skid_clear;
      logic              to_main;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // Ready depends only on registered skid state, never on out_ready.
      assign in_ready    = reset & ~skid_valid;
      assign to_main     = accept & (~out_valid | out_ready);
      assign skid_load   = accept & ~to_main & ~flush;
      assign skid_clear  = flush | (emit & skid_valid);
      assign main_load   = ~flush & (to_main | (emit & skid_valid));
      assign main_clear  = flush | (emit & ~main_load);
      assign main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
      assign main_data_d = skid_valid ? skid_data : in_data;

      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
    end else begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end
  endgenerate

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + COUNT_W'(accept) - COUNT_W'(emit);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_buf : both depths against a queue reference model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_stage_buf;

  typedef logic [142:0] beat_t;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [14:0]   in_ctrl;
  logic [127:0]  in_data;
  logic          flush;
  logic          out_ready;

  logic          in_ready1, out_valid1, count1;
  logic [14:0]   out_ctrl1;
  logic [127:0]  out_data1;
  logic          in_ready2, out_valid2;
  logic [1:0]    count2;
  logic [14:0]   out_ctrl2;
  logic [127:0]  out_data2;

  int n_checks;
  int n_fail;

  beat_t        mq   [2][$];
  logic [127:0] held [2];

  logic [1:0]   rdy_a, vld_a;
  logic [14:0]  ctl_a [2];
  logic [127:0] dat_a [2];
  logic [1:0]   cnt_a [2];

  pipe_stage_buf #(.DATA_W(128), .CTRL_W(15), .DEPTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .count(count1)
  );

  pipe_stage_buf #(.DATA_W(128), .CTRL_W(15), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2),
    .out_data(out_data2), .count(count2)
  );

  assign rdy_a    = {in_ready2, in_ready1};
  assign vld_a    = {out_valid2, out_valid1};
  assign ctl_a[0] = out_ctrl1;
  assign ctl_a[1] = out_ctrl2;
  assign dat_a[0] = out_data1;
  assign dat_a[1] = out_data2;
  assign cnt_a[0] = {1'b0, count1};
  assign cnt_a[1] = count2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, compare just after, advance the model at the rising edge.
  task automatic step(input logic rst_n, input logic vin, input logic [14:0] c,
                      input logic [127:0] dt, input logic ordy, input logic fl);
    logic [1:0]   acc;
    logic [1:0]   emt;
    beat_t        head;
    logic [14:0]  hctrl;
    logic [127:0] hdata;
    logic         exp_rdy;
    int           sz;
    @(negedge clk);
    reset     = rst_n;
    in_valid  = vin;
    in_ctrl   = c;
    in_data   = dt;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz      = mq[d].size();
      exp_rdy = rst_n && ((sz < d + 1) || (d == 0 && ordy));
      head    = (sz > 0) ? mq[d][0] : '0;
      hctrl   = head[142:128];
      hdata   = head[127:0];
      check_eq($sformatf("d%0d in_ready", d + 1), 128'(rdy_a[d]), 128'(exp_rdy));
      check_eq($sformatf("d%0d out_valid", d + 1), 128'(vld_a[d]), 128'(sz > 0));
      check_eq($sformatf("d%0d out_ctrl", d + 1), 128'(ctl_a[d]), (sz > 0) ? 128'(hctrl) : 128'(0));
      check_eq($sformatf("d%0d out_data", d + 1), dat_a[d], (sz > 0) ? hdata : held[d]);
      check_eq($sformatf("d%0d count", d + 1), 128'(cnt_a[d]), 128'(sz));
      acc[d] = vin & exp_rdy;
      emt[d] = (sz > 0) & ordy;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        mq[d].delete();
        held[d] = '0;
      end else begin
        if (mq[d].size() > 0) begin
          head    = mq[d][0];
          held[d] = head[127:0];
        end
        if (emt[d]) void'(mq[d].pop_front());
        if (acc[d]) mq[d].push_back({c, dt});
        if (fl) mq[d].delete();
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    held[0]   = '0;
    held[1]   = '0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset with upstream pushing, then idle release.
    repeat (3) step(1'b0, 1'b1, 15'h7FFF, 128'h55, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 15'h0, 128'h0, 1'b1, 1'b0);

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 15'h7FFF, 128'(32'h10 + i), 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 15'h0, 128'h0, 1'b1, 1'b0);

    // Backpressure fills the skid, then drains in order.
    step(1'b1, 1'b1, 15'h0123, 128'hA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 15'h0456, 128'hB, 1'b0, 1'b0);
    step(1'b1, 1'b0, 15'h0, 128'h0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 15'h0, 128'h0, 1'b1, 1'b0);

    // Flush while full with a beat arriving.
    step(1'b1, 1'b1, 15'h0123, 128'hA, 1'b0, 1'b0);
    step(1'b1, 1'b1, 15'h0456, 128'hB, 1'b0, 1'b0);
    step(1'b1, 1'b1, 15'h0789, 128'hC, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 15'h0, 128'h0, 1'b1, 1'b0);

    // Bubble after a full-control beat: ctrl must drop, data must hold.
    step(1'b1, 1'b1, 15'h7FFF, 128'h77, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 15'h0, 128'h0, 1'b1, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(99) != 0),
           ($urandom_range(99) < 70),
           15'($urandom()),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           ($urandom_range(99) < 60),
           ($urandom_range(99) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Generic, parametrised pipeline-stage register that replaces the hard-wired EN-gated stage registers between pipeline stages (decode→execute first).
- Carries a valid bit with valid/ready backpressure instead of a bare enable.
- Supports synchronous flush for branch/jump redirect.
- Zeroes control bits on bubbles, so a killed or empty slot can never write a register or memory.
- Optional second skid entry gives full throughput with a registered in_ready.

Parameters:
DATA_W, 128, payload width: operands, register numbers, immediate, PC, PC+4; never cleared on bubble.
CTRL_W, 15, control bundle width: ResultSrc, MemWrite, ALUSrc, RegWrite, Jump, Branch, ALUControl, MemRead, funct3; forced to 0 whenever the slot is invalid.
DEPTH, 1, entries: 1 = single register with combinational ready; 2 = main + skid register; other values are illegal (elaboration error).

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream payload
flush  input  1  synchronous kill of all held and incoming beats
out_valid  output  1  downstream beat present
out_ready  input  1  downstream consumes the beat this cycle
out_ctrl  output  CTRL_W  control bundle; 0 when out_valid=0
out_data  output  DATA_W  payload; holds its last value when invalid
count  output  $clog2(DEPTH+1)  number of occupied entries, 0..DEPTH

Behaviour:
Handshake and reset:
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- While reset=0: in_ready=0 (combinational on reset).
- Reset values, first cycle after reset=0 is sampled: out_valid=0, out_ctrl=0, out_data=0, count=0, skid entry empty.

DEPTH=1:
- in_ready = reset & (!out_valid | out_ready).
- On Accept: out_ctrl/out_data <= in_ctrl/in_data and out_valid <= 1 at the next edge. Latency 1 cycle.
- Emit without Accept: out_valid <= 0, out_ctrl <= 0, out_data kept.
- Simultaneous Emit and Accept: the new beat replaces the old one; full throughput.

DEPTH=2:
- in_ready = reset & !skid_valid. Registered, with no combinational path from out_ready.
- Accept when main is empty, or main is emitting with skid empty: the beat goes to main.
- Accept while main holds and out_ready=0: the beat goes to skid.
- Emit with skid valid: main <= skid and skid empties. A concurrent Accept is impossible because in_ready=0.
- Latency is 1 cycle when the skid is empty. Order is strictly FIFO.
- Full (count=2): in_ready=0 and both entries are held stable.

Rules common to both depths:
- Stability: while out_valid & !out_ready, out_ctrl and out_data must not change.
- Flush has the highest priority after reset. At the edge where flush=1:
  - All valids go to 0, out_ctrl goes to 0 and count goes to 0.
  - A beat accepted in that cycle is discarded.
  - An Emit in that cycle still counts as consumed downstream.
  - in_ready is unaffected by flush.
- flush and reset are held for several cycles: state stays empty and there is no X on outputs.
- Reset asserted mid-transfer: held beats are dropped, same as flush. There is no partial state.
- count is registered and equals (out_valid + skid_valid).

Decomposition:
- Package pipe_pkg holds:
  - the decode_ctrl_t packed struct (ResultSrc[1:0], MemWrite, ALUSrc, RegWrite, Jump, Branch, ALUControl[3:0], MemRead, funct3[2:0]);
  - CTRL_W = $bits(decode_ctrl_t);
  - the DEPTH_PLAIN=1 and DEPTH_SKID=2 constants.
- One sub-module, pipe_slot: a single valid+ctrl+data register with load, clear and ctrl-zero-on-invalid. It is instantiated once for main and once for skid when DEPTH=2.

Test Plan:
1. Reset and idle (both DEPTH): hold reset=0 for 3 cycles with in_valid=1 → in_ready=0, out_valid=0, out_ctrl=0, count=0. Release reset with in_valid=0 → in_ready=1 and all outputs stay 0.
2. Streaming (DEPTH=1 and 2): out_ready=1, beats data=0x10..0x17 and ctrl=0x7FFF over 8 back-to-back cycles → outputs appear one cycle later in order with no gaps, and count stays ≤1.
3. Backpressure (DEPTH=2): send beat A=0xA, then B=0xB, with out_ready=0 → count=2, in_ready=0, out_data holds 0xA. Raise out_ready → 0xA then 0xB emitted on consecutive cycles, then in_ready=1.
4. Flush: fill with count=2 (DEPTH=2), then assert flush with in_valid=1 and data=0xC → next cycle out_valid=0, out_ctrl=0, count=0, and 0xC never appears at the output.
5. Bubble control zeroing: accept ctrl=0x7FFF (RegWrite and MemWrite set), emit it, then in_valid=0 → out_ctrl=0 while out_data retains the last payload.
6. Random valid/ready/flush for 10k cycles against a reference queue model → output sequence matches the model, and the stability rule is never violated.
